// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Holds the port enum, pending-response record and address map defaults.
package mem_arb_pkg;

  localparam logic [31:0] DEF_BASEADDR  = 32'h0100_0000;
  localparam logic [31:0] DEF_MEM_BYTES = 32'h0010_0000;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_I,
    PORT_D
  } port_e;

  typedef struct packed {
    port_e port;
    logic  err;
    logic  we;
  } pend_t;

endpackage

// File: rtl/mem_addr_check.sv
// Range and word-alignment check for one request address.
// Ports: i_addr (byte address) -> o_err (1 = outside window or misaligned).
module mem_addr_check
  import mem_arb_pkg::*;
#(
  parameter int unsigned       AWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASEADDR  = AWIDTH'(DEF_BASEADDR),
  parameter logic [AWIDTH-1:0] MEM_BYTES = AWIDTH'(DEF_MEM_BYTES)
) (
  input  logic [AWIDTH-1:0] i_addr,
  output logic              o_err
);

  logic [AWIDTH-1:0] w_off;
  logic              w_below;
  logic              w_above;
  logic              w_misal;

  // Below-base addresses wrap in w_off, so w_below must be checked apart.
  assign w_off   = i_addr - BASEADDR;
  assign w_below = i_addr < BASEADDR;
  assign w_above = w_off >= MEM_BYTES;
  assign w_misal = i_addr[1:0] != 2'b00;
  assign o_err   = w_below | w_above | w_misal;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle memory.
// Ports: clk/rst (sync, active-low); fetch i_req_*/i_rsp_*/i_flush;
//   data d_req_*/d_rsp_*; memory mem_addr_o/mem_data_o/mem_*_en_o/mem_data_i.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       AWIDTH      = 32,
  parameter int unsigned       DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASEADDR    = AWIDTH'(DEF_BASEADDR),
  parameter logic [AWIDTH-1:0] MEM_BYTES   = AWIDTH'(DEF_MEM_BYTES),
  parameter int unsigned       MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [AWIDTH-1:0] i_req_addr,
  output logic              i_req_ready,
  input  logic              i_flush,
  output logic              i_rsp_valid,
  output logic [DWIDTH-1:0] i_rsp_data,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [AWIDTH-1:0] d_req_addr,
  input  logic [DWIDTH-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DWIDTH-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

  pend_t         r_pend;
  logic [SW-1:0] r_dstreak;
  logic [SW-1:0] w_streak_nxt;

  logic w_i_err;
  logic w_d_err;
  logic w_i_cand;
  logic w_grant_i;
  logic w_grant_d;
  logic w_acc;
  logic w_acc_err;
  logic w_acc_we;
  logic w_i_rv;
  logic w_d_rv;
  logic w_rd_ok;

  mem_addr_check #(
    .AWIDTH   (AWIDTH),
    .BASEADDR (BASEADDR),
    .MEM_BYTES(MEM_BYTES)
  ) u_i_chk (
    .i_addr(i_req_addr),
    .o_err (w_i_err)
  );

  mem_addr_check #(
    .AWIDTH   (AWIDTH),
    .BASEADDR (BASEADDR),
    .MEM_BYTES(MEM_BYTES)
  ) u_d_chk (
    .i_addr(d_req_addr),
    .o_err (w_d_err)
  );

  // A flush cycle cannot accept a fetch, so data wins whenever present.
  assign w_i_cand  = i_req_valid && !i_flush;
  assign w_grant_d = rst && d_req_valid &&
                     (!w_i_cand || r_dstreak != SMAX);
  assign w_grant_i = rst && w_i_cand && !w_grant_d;
  assign w_acc     = w_grant_i || w_grant_d;

  assign i_req_ready = w_grant_i;
  assign d_req_ready = w_grant_d;

  assign w_acc_err = w_grant_d ? w_d_err : w_i_err;
  assign w_acc_we  = w_grant_d && d_req_we;

  assign mem_addr_o = w_grant_d ? d_req_addr :
                      w_grant_i ? i_req_addr : '0;
  assign mem_read_en_o  = w_acc && !w_acc_err && !w_acc_we;
  assign mem_write_en_o = w_grant_d && !w_d_err && d_req_we;
  assign mem_data_o     = mem_write_en_o ? d_req_wdata : '0;

  always_comb begin
    w_streak_nxt = r_dstreak;
    if (w_grant_i || !i_req_valid) begin
      w_streak_nxt = '0;
    end else if (w_grant_d && r_dstreak != SMAX) begin
      w_streak_nxt = r_dstreak + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dstreak <= '0;
      r_pend    <= '{port: PORT_NONE, err: 1'b0, we: 1'b0};
    end else begin
      r_dstreak   <= w_streak_nxt;
      r_pend.port <= w_grant_d ? PORT_D :
                     w_grant_i ? PORT_I : PORT_NONE;
      r_pend.err  <= w_acc && w_acc_err;
      r_pend.we   <= w_acc_we;
    end
  end

  // rst gates the responses so an accept just before reset never answers.
  assign w_i_rv  = rst && r_pend.port == PORT_I && !i_flush;
  assign w_d_rv  = rst && r_pend.port == PORT_D;
  assign w_rd_ok = !r_pend.err && !r_pend.we;

  assign i_rsp_valid = w_i_rv;
  assign i_rsp_err   = w_i_rv && r_pend.err;
  assign i_rsp_data  = (w_i_rv && w_rd_ok) ? mem_data_i : '0;

  assign d_rsp_valid = w_d_rv;
  assign d_rsp_err   = w_d_rv && r_pend.err;
  assign d_rsp_data  = (w_d_rv && w_rd_ok) ? mem_data_i : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AWIDTH, 32, address width; DWIDTH, 32, data width; BASEADDR, 32'h0100_0000, memory base byte address; MEM_BYTES, 32'h0010_0000, memory size in bytes; MAX_DSTREAK, 4, max consecutive data grants while fetch waits.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 clock; single clock domain, all logic on rising edge.
- rst in 1 reset; synchronous, active-low.
- i_req_valid in 1, i_req_addr in AWIDTH: fetch read request.
- i_req_ready out 1: fetch request accepted this cycle.
- i_flush in 1: drop pending fetch response.
- i_rsp_valid out 1, i_rsp_data out DWIDTH, i_rsp_err out 1: fetch response.
- d_req_valid in 1, d_req_we in 1, d_req_addr in AWIDTH, d_req_wdata in DWIDTH: data read/write request.
- d_req_ready out 1: data request accepted this cycle.
- d_rsp_valid out 1, d_rsp_data out DWIDTH, d_rsp_err out 1: data response; writes ack with data 0.
- mem_addr_o out AWIDTH, mem_data_o out DWIDTH, mem_read_en_o out 1, mem_write_en_o out 1: shared memory port.
- mem_data_i in DWIDTH: memory read data, valid one cycle after mem_read_en_o.

Function
REQ-003 Accept SHALL mean valid && ready in the same cycle; at most one port accepted per cycle.
REQ-004 ready SHALL be combinational from valids and arbitration state; no combinational path from mem_data_i to any ready.
REQ-005 Arbitration SHALL be: only one valid -> grant it; both valid -> grant data unless dstreak == MAX_DSTREAK, then grant fetch.
REQ-006 dstreak (counter, width clog2(MAX_DSTREAK+1)) SHALL increment on each data grant with i_req_valid high, saturate at MAX_DSTREAK, clear on fetch grant or any cycle i_req_valid is low.
REQ-007 Address check SHALL flag error when addr < BASEADDR, addr - BASEADDR >= MEM_BYTES (unsigned, AWIDTH bits, no wrap), or addr[1:0] != 0.
REQ-008 Accepted error-free request SHALL drive mem_addr_o = addr and mem_read_en_o = !we (fetch: 1), or mem_write_en_o = we with mem_data_o = wdata, in the accept cycle.
REQ-009 Accepted error request SHALL keep both memory enables 0.
REQ-010 mem_read_en_o and mem_write_en_o SHALL be 0 in cycles with no accept; never both 1.
REQ-011 Response SHALL appear exactly one cycle after accept on the granted port: rsp_valid=1, rsp_data = mem_data_i for good reads, 0 for writes/errors; rsp_err = error flag.
REQ-012 Throughput SHALL be one accept per cycle; responses are not backpressured.
REQ-013 Pending-response register SHALL hold port (NONE/I/D), error flag, and we bit.
REQ-014 i_flush high SHALL suppress i_rsp_valid for a fetch accepted the previous cycle and block fetch accept in the same cycle.
REQ-015 Data requests in a flush cycle SHALL arbitrate normally.
REQ-016 Response outputs with rsp_valid=0 SHALL be 0.

Reset
REQ-017 While rst=0 at a clock edge: pending port <- NONE, dstreak <- 0.
REQ-018 While rst=0, all ready, rsp_valid, rsp_err, rsp_data, memory enables, mem_addr_o, and mem_data_o SHALL be 0.
REQ-019 A request accepted the cycle before reset assertion SHALL produce no response.
REQ-020 First accept SHALL be possible in the first cycle with rst=1.

Structure
REQ-021 Package mem_arb_pkg SHALL hold port_e enum {PORT_NONE, PORT_I, PORT_D}, pending-response struct, and default BASEADDR/MEM_BYTES constants.
REQ-022 Address/alignment check SHALL be a sub-module mem_addr_check, one instance per port.

Verification
REQ-023 Fetch-only: i_req_addr=32'h0100_0000, memory word 32'h0000_0013 -> i_req_ready same cycle, i_rsp_valid next cycle with data 32'h0000_0013, err 0.
REQ-024 Contention: both valid continuously for 6 cycles -> grant order D,D,D,D,I,D; dstreak reaches 4 and then clears.
REQ-025 Errors: d_req_addr=32'h0100_0002 and i_req_addr=32'h0110_0000 -> err=1, data 0, memory enables never 1.
REQ-026 Write then read: d write 32'hDEAD_BEEF to 32'h0100_0010, then d read same addr -> ack data 0, then read data 32'hDEAD_BEEF on consecutive cycles.
REQ-027 Flush: fetch accepted cycle N, i_flush=1 at N+1 -> no i_rsp_valid at N+1, no fetch accept at N+1.
REQ-028 Reset: rst=0 the cycle after a data read accept -> no d_rsp_valid; all outputs 0 during reset.
